// File: rtl/mem_bridge_if.sv
// External memory bus: single outstanding req/ack transfer.
// The bridge drives the request side (master); the memory answers (slave).
interface mem_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;
  logic                  bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/mem_bridge.sv
// Memory-access stage behind the multicycle control FSM: turns fetch/load/store strobes
// into one req/ack bus transfer, fills ir/mdr, and stalls the FSM until the access ends.
module mem_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ir_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic [31:0]           ir,
  output logic [31:0]           mdr,
  output logic                  fault,
  output logic [1:0]            fault_cause,
  mem_bridge_if.master          bus
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StFault} state_e;
  typedef enum logic [1:0] {KindFetch, KindLoad, KindStore} kind_e;

  state_e            state_q;
  kind_e             kind_q;
  kind_e             kind_d;
  logic [CntW-1:0]   cnt_q;
  logic              req;

  assign req = ir_write | mem_read | mem_write;

  always_comb begin
    kind_d = KindStore;
    if (ir_write) begin
      kind_d = KindFetch;
    end else if (mem_read) begin
      kind_d = KindLoad;
    end
  end

  always_comb begin
    stall = 1'b1;
    unique case (state_q)
      StIdle:  stall = req;
      StBusy:  stall = 1'b1;
      StDone:  stall = 1'b0;
      StFault: stall = 1'b1;
      default: stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      kind_q        <= KindFetch;
      cnt_q         <= '0;
      ir            <= '0;
      mdr           <= '0;
      fault         <= 1'b0;
      fault_cause   <= 2'b00;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (addr[1:0] != 2'b00) begin
              state_q     <= StFault;
              fault       <= 1'b1;
              fault_cause <= 2'b01;
            end else begin
              state_q       <= StBusy;
              kind_q        <= kind_d;
              cnt_q         <= '0;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= (kind_d == KindStore);
              bus.bus_addr  <= addr;
              bus.bus_wdata <= wdata;
            end
          end
        end
        StBusy: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (bus.bus_ack) begin
            if (kind_q == KindFetch) begin
              ir <= bus.bus_rdata;
            end else if (kind_q == KindLoad) begin
              mdr <= bus.bus_rdata;
            end
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            state_q     <= StDone;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= 2'b10;
            state_q     <= StFault;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        StFault: state_q <= StFault;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: fetch/load/store, waits, timeout, misalignment, reset.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_write, mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic        stall, fault;
  logic [31:0] ir, mdr;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_errors = 0;

  int          req_cycles, stall_cycles;
  logic        busy_stable;
  logic [31:0] first_addr, first_wdata;
  logic        first_we;
  logic        saw_req, flag_ok;

  always #5 clk = ~clk;

  mem_bridge_if #(.ADDR_WIDTH(32)) bus ();

  mem_bridge #(
    .ADDR_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .ir         (ir),
    .mdr        (mdr),
    .fault      (fault),
    .fault_cause(fault_cause),
    .bus        (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.bus_ack = 1'b0;
    drop_reqs();
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Called in IDLE with the request already driven; returns in the DONE cycle.
  task automatic access(input int waits, input logic [31:0] rdata);
    #1;
    req_cycles   = 0;
    stall_cycles = 0;
    busy_stable  = 1'b1;
    if (stall) stall_cycles++;
    for (int i = 0; i <= waits; i++) begin
      step();
      if (bus.bus_req) req_cycles++;
      if (stall) stall_cycles++;
      if (i == 0) begin
        first_addr  = bus.bus_addr;
        first_wdata = bus.bus_wdata;
        first_we    = bus.bus_we;
      end else if (bus.bus_addr !== first_addr || bus.bus_wdata !== first_wdata ||
                   bus.bus_we !== first_we || bus.bus_req !== 1'b1) begin
        busy_stable = 1'b0;
      end
      if (i == waits) begin
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = rdata;
      end
    end
    step();
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ir"}, ir, 32'h0);
    check({tag, "_mdr"}, mdr, 32'h0);
    check({tag, "_req"}, {31'h0, bus.bus_req}, 32'h0);
    check({tag, "_we"}, {31'h0, bus.bus_we}, 32'h0);
    check({tag, "_addr"}, bus.bus_addr, 32'h0);
    check({tag, "_wdata"}, bus.bus_wdata, 32'h0);
    check({tag, "_fault"}, {31'h0, fault}, 32'h0);
    check({tag, "_cause"}, {30'h0, fault_cause}, 32'h0);
    check({tag, "_stall"}, {31'h0, stall}, 32'h0);
  endtask

  initial begin
    drop_reqs();
    addr          = '0;
    wdata         = '0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    do_reset();
    check_reset_state("rst");

    // Fetch, zero wait
    ir_write = 1'b1;
    addr     = 32'h0000_0010;
    access(0, 32'h0050_0093);
    check("fetch_req_cycles", req_cycles, 1);
    check("fetch_addr", first_addr, 32'h10);
    check("fetch_we", {31'h0, first_we}, 32'h0);
    check("fetch_stall_hi", stall_cycles, 2);
    check("fetch_done_stall", {31'h0, stall}, 32'h0);
    check("fetch_done_req", {31'h0, bus.bus_req}, 32'h0);
    check("fetch_ir", ir, 32'h0050_0093);
    check("fetch_mdr", mdr, 32'h0);
    drop_reqs();
    step();

    // Load, 3 wait states
    mem_read = 1'b1;
    addr     = 32'h100;
    access(3, 32'hDEAD_BEEF);
    check("load_req_cycles", req_cycles, 4);
    check("load_stall_hi", stall_cycles, 5);
    check("load_done_stall", {31'h0, stall}, 32'h0);
    check("load_mdr", mdr, 32'hDEAD_BEEF);
    check("load_ir", ir, 32'h0050_0093);
    drop_reqs();
    step();

    // Store, 1 wait
    mem_write = 1'b1;
    addr      = 32'h104;
    wdata     = 32'h1234_5678;
    access(1, 32'hFFFF_0000);
    check("store_req_cycles", req_cycles, 2);
    check("store_we", {31'h0, first_we}, 32'h1);
    check("store_wdata", first_wdata, 32'h1234_5678);
    check("store_stable", {31'h0, busy_stable}, 32'h1);
    check("store_ir", ir, 32'h0050_0093);
    check("store_mdr", mdr, 32'hDEAD_BEEF);
    drop_reqs();
    step();

    // Priority: fetch beats load; then back-to-back store right after DONE
    ir_write = 1'b1;
    mem_read = 1'b1;
    addr     = 32'h30;
    access(0, 32'h1111_2222);
    check("prio_we", {31'h0, first_we}, 32'h0);
    check("prio_ir", ir, 32'h1111_2222);
    check("prio_mdr", mdr, 32'hDEAD_BEEF);
    drop_reqs();
    mem_write = 1'b1;
    addr      = 32'h40;
    wdata     = 32'hCAFE_F00D;
    step();
    access(0, 32'h0);
    check("b2b_req_cycles", req_cycles, 1);
    check("b2b_addr", first_addr, 32'h40);
    check("b2b_we", {31'h0, first_we}, 32'h1);
    check("b2b_wdata", first_wdata, 32'hCAFE_F00D);
    drop_reqs();
    step();

    // Ack on the 16th BUSY cycle wins over the timeout
    mem_read = 1'b1;
    addr     = 32'h200;
    access(15, 32'h0BAD_F00D);
    check("late_ack_req_cycles", req_cycles, 16);
    check("late_ack_fault", {31'h0, fault}, 32'h0);
    check("late_ack_mdr", mdr, 32'h0BAD_F00D);
    check("late_ack_stall", {31'h0, stall}, 32'h0);
    drop_reqs();
    step();

    // Never ack: timeout after 16 BUSY cycles
    mem_read = 1'b1;
    addr     = 32'h204;
    step();
    saw_req = 1'b1;
    for (int i = 1; i < 16; i++) begin
      step();
      if (bus.bus_req !== 1'b1 || fault !== 1'b0) saw_req = 1'b0;
    end
    check("to_busy_held", {31'h0, saw_req}, 32'h1);
    step();
    check("to_fault", {31'h0, fault}, 32'h1);
    check("to_cause", {30'h0, fault_cause}, 32'h2);
    check("to_req", {31'h0, bus.bus_req}, 32'h0);
    check("to_mdr", mdr, 32'h0BAD_F00D);
    drop_reqs();
    step();
    check("to_stall_sticky", {31'h0, stall}, 32'h1);
    do_reset();

    // Reset during BUSY with ack high: no capture, bus_req drops
    mem_read = 1'b1;
    addr     = 32'h50;
    step();
    check("rbusy_req", {31'h0, bus.bus_req}, 32'h1);
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 32'h7777_7777;
    reset         = 1'b1;
    step();
    reset       = 1'b0;
    bus.bus_ack = 1'b0;
    drop_reqs();
    #1;
    check("rbusy_mdr", mdr, 32'h0);
    check("rbusy_ir", ir, 32'h0);
    check("rbusy_req_low", {31'h0, bus.bus_req}, 32'h0);
    check("rbusy_stall", {31'h0, stall}, 32'h0);
    ir_write = 1'b1;
    addr     = 32'h60;
    access(0, 32'hA5A5_5A5A);
    check("rbusy_refetch_ir", ir, 32'hA5A5_5A5A);
    drop_reqs();
    step();

    // Misaligned load: no bus cycle, sticky fault until reset
    mem_read = 1'b1;
    addr     = 32'h102;
    #1;
    check("mis_stall_idle", {31'h0, stall}, 32'h1);
    saw_req = 1'b0;
    flag_ok = 1'b1;
    step();
    check("mis_fault", {31'h0, fault}, 32'h1);
    check("mis_cause", {30'h0, fault_cause}, 32'h1);
    drop_reqs();
    for (int i = 0; i < 5; i++) begin
      if (bus.bus_req) saw_req = 1'b1;
      if (stall !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'b01) flag_ok = 1'b0;
      step();
    end
    check("mis_no_req", {31'h0, saw_req}, 32'h0);
    check("mis_sticky", {31'h0, flag_ok}, 32'h1);
    check("mis_ir_held", ir, 32'hA5A5_5A5A);
    do_reset();
    check_reset_state("mis_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
